ram_arbiter: RTL and testbench

- Two-requester arbiter sharing one single-port synchronous RAM between port 0 (instruction fetch) and port 1 (load/store).
- The RAM has byte write enables and one-cycle read latency.
- The arbiter grants one access per cycle, round-robin, and tracks the owner of each in-flight read.
- Each port has a response buffer that holds read data until the port accepts it.

---
 rtl/ram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 533 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port synchronous RAM
// between an instruction-fetch port (0) and a load/store port (1).
// Writes complete in their grant cycle. Reads return two edges after the grant
// through a one-entry response buffer per port. A port may hold at most one
// read in flight, so its response buffer can never be overrun.
module ram_arbiter #(
    parameter int DATA_WHITH = 32,
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_WHITH = 10,
    parameter int DATA_BYTE  = DATA_WHITH / DATA_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    // port 0: instruction fetch
    input  logic                  p0_req,
    input  logic [DATA_BYTE-1:0]  p0_we,
    input  logic [ADDR_WHITH-1:0] p0_addr,
    input  logic [DATA_WHITH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WHITH-1:0] p0_rdata,
    input  logic                  p0_rready,
    // port 1: load/store
    input  logic                  p1_req,
    input  logic [DATA_BYTE-1:0]  p1_we,
    input  logic [ADDR_WHITH-1:0] p1_addr,
    input  logic [DATA_WHITH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WHITH-1:0] p1_rdata,
    input  logic                  p1_rready,
    // single-port RAM
    output logic                  ram_cs,
    output logic [DATA_BYTE-1:0]  ram_we,
    output logic [ADDR_WHITH-1:0] ram_addr,
    output logic [DATA_WHITH-1:0] ram_wdata,
    input  logic [DATA_WHITH-1:0] ram_rdata
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // round-robin history and in-flight read tracking
    port_e                 last_q, last_d;
    port_e                 rd_owner_q, rd_owner_d;
    logic                  rd_pend_q, rd_pend_d;

    // per-port response buffers
    logic                  p0_rvalid_q, p0_rvalid_d;
    logic                  p1_rvalid_q, p1_rvalid_d;
    logic [DATA_WHITH-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_WHITH-1:0] p1_rdata_q, p1_rdata_d;

    // arbitration signals
    logic                  p0_busy, p1_busy;
    logic                  p0_free, p1_free;
    logic                  p0_elig, p1_elig;
    logic                  gnt_any;
    port_e                 win;
    logic                  win_rd;

    // Eligibility: writes always qualify; a read needs no read of its own in
    // flight and a response buffer that is empty or being drained this cycle.
    always_comb begin
        p0_busy = rd_pend_q && (rd_owner_q == PORT0);
        p1_busy = rd_pend_q && (rd_owner_q == PORT1);
        p0_free = !p0_rvalid_q || p0_rready;
        p1_free = !p1_rvalid_q || p1_rready;
        p0_elig = p0_req && ((|p0_we) || (!p0_busy && p0_free));
        p1_elig = p1_req && ((|p1_we) || (!p1_busy && p1_free));
    end

    // Round-robin pick: on a tie the port that did not win last time goes.
    // Reset forces no grant so the RAM is never touched while held in reset.
    always_comb begin
        gnt_any = 1'b0;
        win     = PORT0;
        if (!rst) begin
            if (p0_elig && p1_elig) begin
                gnt_any = 1'b1;
                win     = (last_q == PORT0) ? PORT1 : PORT0;
            end else if (p0_elig) begin
                gnt_any = 1'b1;
                win     = PORT0;
            end else if (p1_elig) begin
                gnt_any = 1'b1;
                win     = PORT1;
            end
        end
    end

    assign p0_gnt = gnt_any && (win == PORT0);
    assign p1_gnt = gnt_any && (win == PORT1);

    // RAM drive: the winner's request goes straight through; idle bus is all zero.
    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt_any) begin
            ram_cs = 1'b1;
            if (win == PORT0) begin
                ram_we    = p0_we;
                ram_addr  = p0_addr;
                ram_wdata = p0_wdata;
            end else begin
                ram_we    = p1_we;
                ram_addr  = p1_addr;
                ram_wdata = p1_wdata;
            end
        end
    end

    assign win_rd = gnt_any && (ram_we == '0);

    // Arbitration history and read-owner bookkeeping for the next cycle.
    always_comb begin
        last_d     = gnt_any ? win : last_q;
        rd_pend_d  = win_rd;
        rd_owner_d = win_rd ? win : rd_owner_q;
    end

    // Port 0 response buffer: release on handshake, capture wins over release.
    always_comb begin
        p0_rvalid_d = p0_rvalid_q;
        p0_rdata_d  = p0_rdata_q;
        if (p0_rvalid_q && p0_rready) begin
            p0_rvalid_d = 1'b0;
        end
        if (rd_pend_q && (rd_owner_q == PORT0)) begin
            p0_rvalid_d = 1'b1;
            p0_rdata_d  = ram_rdata;
        end
    end

    // Port 1 response buffer: same policy as port 0.
    always_comb begin
        p1_rvalid_d = p1_rvalid_q;
        p1_rdata_d  = p1_rdata_q;
        if (p1_rvalid_q && p1_rready) begin
            p1_rvalid_d = 1'b0;
        end
        if (rd_pend_q && (rd_owner_q == PORT1)) begin
            p1_rvalid_d = 1'b1;
            p1_rdata_d  = ram_rdata;
        end
    end

    // State registers; reset discards any read in flight and makes port 0
    // the winner of the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= PORT1;
            rd_owner_q  <= PORT0;
            rd_pend_q   <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            last_q      <= last_d;
            rd_owner_q  <= rd_owner_d;
            rd_pend_q   <= rd_pend_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

    // Structural invariants: one grant at most, never a second read in flight
    // for a port, and a capture never lands on a still-full buffer.
    a_one_gnt: assert property (@(posedge clk) disable iff (rst)
        !(p0_gnt && p1_gnt));
    a_p0_single_rd: assert property (@(posedge clk) disable iff (rst)
        (p0_gnt && (p0_we == '0)) |-> !p0_busy);
    a_p1_single_rd: assert property (@(posedge clk) disable iff (rst)
        (p1_gnt && (p1_we == '0)) |-> !p1_busy);
    a_p0_no_overrun: assert property (@(posedge clk) disable iff (rst)
        p0_busy |-> !p0_rvalid_q);
    a_p1_no_overrun: assert property (@(posedge clk) disable iff (rst)
        p1_busy |-> !p1_rvalid_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a behavioural RAM plus a cycle-level reference
// model that tracks outstanding reads by grant time and the round-robin
// history, driven by directed scenarios and random traffic.
module tb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          req    [2];
    logic [NB-1:0] we     [2];
    logic [AW-1:0] addr   [2];
    logic [DW-1:0] wdata  [2];
    logic          rready [2];
    logic          gnt    [2];
    logic          rvalid [2];
    logic [DW-1:0] rdata  [2];

    logic          ram_cs;
    logic [NB-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] ram [1024];
    logic          ram_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    // reference model state
    int            cyc;
    logic [DW-1:0] mem_ref [1024];
    bit            m_pend [2];
    int            m_pend_cyc [2];
    logic [DW-1:0] m_pend_data [2];
    bit            m_rv [2];
    logic [DW-1:0] m_rd [2];
    int            m_last;
    // expectations for the current cycle
    int            e_win;
    bit            e_gnt [2];

    ram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (req[0]),
        .p0_we     (we[0]),
        .p0_addr   (addr[0]),
        .p0_wdata  (wdata[0]),
        .p0_gnt    (gnt[0]),
        .p0_rvalid (rvalid[0]),
        .p0_rdata  (rdata[0]),
        .p0_rready (rready[0]),
        .p1_req    (req[1]),
        .p1_we     (we[1]),
        .p1_addr   (addr[1]),
        .p1_wdata  (wdata[1]),
        .p1_gnt    (gnt[1]),
        .p1_rvalid (rvalid[1]),
        .p1_rdata  (rdata[1]),
        .p1_rready (rready[1]),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 16) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    // behavioural single-port RAM: byte writes, registered read
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (ram_cs) begin
            ram_rdata <= ram[ram_addr];
            for (int b = 0; b < NB; b++)
                if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_pend[n] = 0;
            m_rv[n]   = 0;
            m_rd[n]   = '0;
        end
        m_last = 1;
    endtask

    // who should win this cycle, from eligibility and tie-break history
    task automatic model_expect();
        bit el [2];
        for (int n = 0; n < 2; n++)
            el[n] = !rst && req[n] && ((we[n] != 0) || (!m_pend[n] && (!m_rv[n] || rready[n])));
        e_win = -1;
        if (el[0] && el[1]) e_win = 1 - m_last;
        else if (el[0]) e_win = 0;
        else if (el[1]) e_win = 1;
        e_gnt[0] = (e_win == 0);
        e_gnt[1] = (e_win == 1);
    endtask

    // advance the model across the coming clock edge
    task automatic model_advance();
        if (rst) begin
            model_reset();
            cyc++;
            return;
        end
        for (int n = 0; n < 2; n++)
            if (m_rv[n] && rready[n]) m_rv[n] = 0;
        for (int n = 0; n < 2; n++)
            if (m_pend[n] && (m_pend_cyc[n] + 2 == cyc + 1)) begin
                m_rv[n]   = 1;
                m_rd[n]   = m_pend_data[n];
                m_pend[n] = 0;
            end
        if (e_win >= 0) begin
            if (we[e_win] == 0) begin
                m_pend[e_win]      = 1;
                m_pend_cyc[e_win]  = cyc;
                m_pend_data[e_win] = mem_ref[addr[e_win]];
            end else begin
                for (int b = 0; b < NB; b++)
                    if (we[e_win][b]) mem_ref[addr[e_win]][8*b +: 8] = wdata[e_win][8*b +: 8];
            end
            m_last = e_win;
        end
        cyc++;
    endtask

    function automatic logic [48:0] obs_bus();
        return {gnt[1], gnt[0], ram_cs, ram_we, ram_addr, ram_wdata};
    endfunction

    function automatic logic [48:0] exp_bus();
        if (e_win < 0) return {e_gnt[1], e_gnt[0], 47'b0};
        return {e_gnt[1], e_gnt[0], 1'b1, we[e_win], addr[e_win], wdata[e_win]};
    endfunction

    function automatic logic [65:0] obs_resp();
        return {rvalid[1], rvalid[0], rdata[1], rdata[0]};
    endfunction

    function automatic logic [65:0] exp_resp();
        return {m_rv[1], m_rv[0], m_rd[1], m_rd[0]};
    endfunction

    task automatic set_port(int n, logic r, logic [NB-1:0] w, logic [AW-1:0] a, logic [DW-1:0] d);
        req[n]   = r;
        we[n]    = w;
        addr[n]  = a;
        wdata[n] = d;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst = (k < 3);
            set_port(0, k < 3, 4'hF, 10'h005, 32'h11111111);
            set_port(1, k < 3, 4'h0, 10'h006, 32'h0);
            rready[0] = 1'b1;
            rready[1] = 1'b1;
            #1;
            model_expect();
            if (k < 3) begin
                total++;
                if (gnt[0] !== 1'b0 || gnt[1] !== 1'b0 || ram_cs !== 1'b0 || ram_we !== 4'h0) begin
                    bad++;
                    $display("FAIL reset_gate cyc=%0d got gnt=%b%b cs=%b we=%h exp all 0", cyc, gnt[1], gnt[0], ram_cs, ram_we);
                end
            end
            total++;
            if (obs_bus() !== exp_bus()) begin
                bad++;
                $display("FAIL reset_bus cyc=%0d got=%h exp=%h", cyc, obs_bus(), exp_bus());
            end
            total++;
            if (obs_resp() !== exp_resp()) begin
                bad++;
                $display("FAIL reset_resp cyc=%0d got=%h exp=%h", cyc, obs_resp(), exp_resp());
            end
            model_advance();
        end
    endtask

    task automatic test_single_read();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_port(0, k == 0, 4'h0, 10'h010, 32'h0);
            set_port(1, 1'b0, 4'h0, 10'h0, 32'h0);
            rready[0] = 1'b1;
            #1;
            model_expect();
            if (k == 0) begin
                total++;
                if (gnt[0] !== 1'b1 || ram_cs !== 1'b1 || ram_we !== 4'h0 || ram_addr !== 10'h010) begin
                    bad++;
                    $display("FAIL rd_grant got gnt=%b cs=%b we=%h addr=%h exp 1 1 0 010", gnt[0], ram_cs, ram_we, ram_addr);
                end
            end
            if (k == 2) begin
                total++;
                if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF) begin
                    bad++;
                    $display("FAIL rd_latency got rvalid=%b rdata=%h exp 1 deadbeef", rvalid[0], rdata[0]);
                end
            end
            if (k == 3) begin
                total++;
                if (rvalid[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_release got rvalid=%b exp 0", rvalid[0]);
                end
            end
            total++;
            if (obs_bus() !== exp_bus()) begin
                bad++;
                $display("FAIL rd_bus cyc=%0d got=%h exp=%h", cyc, obs_bus(), exp_bus());
            end
            total++;
            if (obs_resp() !== exp_resp()) begin
                bad++;
                $display("FAIL rd_resp cyc=%0d got=%h exp=%h", cyc, obs_resp(), exp_resp());
            end
            model_advance();
        end
    endtask

    task automatic test_write_contention();
        logic [DW-1:0] orig2;
        int prev_w;
        int w;
        orig2  = mem_ref[2];
        prev_w = -1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            set_port(0, k < 10, 4'h0, 10'h001, 32'h0);
            set_port(1, k < 10, 4'b0011, 10'h002, 32'h12345678);
            rready[0] = 1'b1;
            rready[1] = 1'b1;
            #1;
            model_expect();
            if (k < 10) begin
                w = (gnt[0] === 1'b1) ? 0 : ((gnt[1] === 1'b1) ? 1 : -1);
                if (k > 0) begin
                    total++;
                    if (w != 1 - prev_w) begin
                        bad++;
                        $display("FAIL wc_alternate step=%0d got winner=%0d exp %0d", k, w, 1 - prev_w);
                    end
                end
                prev_w = w;
            end else begin
                total++;
                if (ram[2] !== {orig2[31:16], 16'h5678}) begin
                    bad++;
                    $display("FAIL wc_bytes got mem2=%h exp %h", ram[2], {orig2[31:16], 16'h5678});
                end
            end
            total++;
            if (rvalid[1] !== 1'b0) begin
                bad++;
                $display("FAIL wc_no_resp step=%0d got p1_rvalid=%b exp 0", k, rvalid[1]);
            end
            total++;
            if (obs_bus() !== exp_bus()) begin
                bad++;
                $display("FAIL wc_bus cyc=%0d got=%h exp=%h", cyc, obs_bus(), exp_bus());
            end
            total++;
            if (obs_resp() !== exp_resp()) begin
                bad++;
                $display("FAIL wc_resp cyc=%0d got=%h exp=%h", cyc, obs_resp(), exp_resp());
            end
            model_advance();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        exp_a = mem_ref[10'h020];
        exp_b = mem_ref[10'h021];
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            set_port(0, 1'b0, 4'h0, 10'h0, 32'h0);
            if (k == 0) set_port(1, 1'b1, 4'h0, 10'h020, 32'h0);
            else if (k >= 3 && k <= 6) set_port(1, 1'b1, 4'h0, 10'h021, 32'h0);
            else set_port(1, 1'b0, 4'h0, 10'h0, 32'h0);
            rready[1] = (k >= 6);
            #1;
            model_expect();
            if (k >= 3 && k <= 5) begin
                total++;
                if (gnt[1] !== 1'b0 || rvalid[1] !== 1'b1 || rdata[1] !== exp_a) begin
                    bad++;
                    $display("FAIL bp_hold step=%0d got gnt=%b rvalid=%b rdata=%h exp 0 1 %h", k, gnt[1], rvalid[1], rdata[1], exp_a);
                end
            end
            if (k == 6) begin
                total++;
                if (gnt[1] !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_release_gnt got gnt=%b exp 1", gnt[1]);
                end
            end
            if (k == 8) begin
                total++;
                if (rvalid[1] !== 1'b1 || rdata[1] !== exp_b) begin
                    bad++;
                    $display("FAIL bp_second got rvalid=%b rdata=%h exp 1 %h", rvalid[1], rdata[1], exp_b);
                end
            end
            total++;
            if (obs_bus() !== exp_bus()) begin
                bad++;
                $display("FAIL bp_bus cyc=%0d got=%h exp=%h", cyc, obs_bus(), exp_bus());
            end
            total++;
            if (obs_resp() !== exp_resp()) begin
                bad++;
                $display("FAIL bp_resp cyc=%0d got=%h exp=%h", cyc, obs_resp(), exp_resp());
            end
            model_advance();
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst = (k == 1);
            rready[0] = 1'b1;
            rready[1] = 1'b1;
            case (k)
                0: begin
                    set_port(0, 1'b1, 4'h0, 10'h033, 32'h0);
                    set_port(1, 1'b0, 4'h0, 10'h0, 32'h0);
                end
                1: begin
                    set_port(0, 1'b0, 4'h0, 10'h0, 32'h0);
                    set_port(1, 1'b1, 4'hF, 10'h040, 32'hCAFEF00D);
                end
                2: begin
                    set_port(0, 1'b1, 4'hF, 10'h041, 32'h01020304);
                    set_port(1, 1'b1, 4'hF, 10'h040, 32'hCAFEF00D);
                end
                default: begin
                    set_port(0, 1'b0, 4'h0, 10'h0, 32'h0);
                    set_port(1, 1'b0, 4'h0, 10'h0, 32'h0);
                end
            endcase
            #1;
            if (k == 1) model_reset();
            model_expect();
            if (k == 1) begin
                total++;
                if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0 || gnt[1] !== 1'b0 || ram_cs !== 1'b0) begin
                    bad++;
                    $display("FAIL mr_state got rvalid=%b rdata=%h gnt1=%b cs=%b exp 0 0 0 0", rvalid[0], rdata[0], gnt[1], ram_cs);
                end
            end
            if (k == 2) begin
                total++;
                if (gnt[0] !== 1'b1 || gnt[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL mr_first_contest got gnt=%b%b exp 01", gnt[1], gnt[0]);
                end
            end
            if (k >= 2) begin
                total++;
                if (rvalid[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL mr_no_resp step=%0d got rvalid=%b exp 0", k, rvalid[0]);
                end
            end
            total++;
            if (obs_bus() !== exp_bus()) begin
                bad++;
                $display("FAIL mr_bus cyc=%0d got=%h exp=%h", cyc, obs_bus(), exp_bus());
            end
            total++;
            if (obs_resp() !== exp_resp()) begin
                bad++;
                $display("FAIL mr_resp cyc=%0d got=%h exp=%h", cyc, obs_resp(), exp_resp());
            end
            model_advance();
        end
    endtask

    task automatic test_back_to_back();
        int grants;
        bit next_new [2];
        grants      = 0;
        next_new[0] = 1;
        next_new[1] = 1;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            rready[0] = 1'b1;
            rready[1] = 1'b1;
            for (int n = 0; n < 2; n++) begin
                if (k < 2 || k >= 22) set_port(n, 1'b0, 4'h0, 10'h0, 32'h0);
                else if (next_new[n] || !req[n]) set_port(n, 1'b1, 4'h0, AW'($urandom_range(0, 1023)), 32'h0);
            end
            #1;
            model_expect();
            if (k >= 2 && k < 22 && (gnt[0] === 1'b1 || gnt[1] === 1'b1)) grants++;
            total++;
            if (obs_bus() !== exp_bus()) begin
                bad++;
                $display("FAIL b2b_bus cyc=%0d got=%h exp=%h", cyc, obs_bus(), exp_bus());
            end
            total++;
            if (obs_resp() !== exp_resp()) begin
                bad++;
                $display("FAIL b2b_resp cyc=%0d got=%h exp=%h", cyc, obs_resp(), exp_resp());
            end
            next_new[0] = e_gnt[0];
            next_new[1] = e_gnt[1];
            model_advance();
        end
        total++;
        if (grants != 20) begin
            bad++;
            $display("FAIL b2b_throughput got grants=%0d exp 20", grants);
        end
    endtask

    task automatic test_idle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rready[0] = 1'b1;
            rready[1] = 1'b1;
            if (k == 0) set_port(0, 1'b1, 4'h1, 10'h050, 32'h000000AA);
            else if (k == 6) set_port(0, 1'b1, 4'hF, 10'h051, 32'h55555555);
            else set_port(0, 1'b0, 4'h0, 10'h0, 32'h0);
            if (k == 6) set_port(1, 1'b1, 4'hF, 10'h052, 32'h66666666);
            else set_port(1, 1'b0, 4'h0, 10'h0, 32'h0);
            #1;
            model_expect();
            if (k >= 1 && k <= 5) begin
                total++;
                if (ram_cs !== 1'b0 || ram_we !== 4'h0) begin
                    bad++;
                    $display("FAIL idle_bus step=%0d got cs=%b we=%h exp 0 0", k, ram_cs, ram_we);
                end
            end
            if (k == 6) begin
                total++;
                if (gnt[1] !== 1'b1 || gnt[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_rr_hold got gnt=%b%b exp 10", gnt[1], gnt[0]);
                end
            end
            total++;
            if (obs_bus() !== exp_bus()) begin
                bad++;
                $display("FAIL idle_model_bus cyc=%0d got=%h exp=%h", cyc, obs_bus(), exp_bus());
            end
            model_advance();
        end
    endtask

    task automatic test_random();
        bit next_new [2];
        next_new[0] = 1;
        next_new[1] = 1;
        for (int k = 0; k < 410; k++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                rready[n] = (k >= 400) || ($urandom_range(0, 2) != 0);
                if (k >= 400) set_port(n, 1'b0, 4'h0, 10'h0, 32'h0);
                else if (next_new[n] || !req[n])
                    set_port(n, $urandom_range(0, 3) != 0,
                             ($urandom_range(0, 2) == 0) ? NB'($urandom_range(1, 15)) : 4'h0,
                             AW'($urandom_range(0, 15)), $urandom);
            end
            #1;
            model_expect();
            total++;
            if (obs_bus() !== exp_bus()) begin
                bad++;
                $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", cyc, obs_bus(), exp_bus());
            end
            total++;
            if (obs_resp() !== exp_resp()) begin
                bad++;
                $display("FAIL rnd_resp cyc=%0d got=%h exp=%h", cyc, obs_resp(), exp_resp());
            end
            next_new[0] = e_gnt[0];
            next_new[1] = e_gnt[1];
            model_advance();
        end
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            set_port(n, 1'b0, 4'h0, 10'h0, 32'h0);
            rready[n] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) mem_ref[i] = init_word(i);
        model_reset();
        cyc = 0;
        test_reset();
        test_single_read();
        test_write_contention();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
